// File: rtl/mux_sel_pkg.sv
// Shared types and helpers for the 4:1 mux select sequencer.
// Combinational only; no latency. No backpressure; nothing is held here.
package mux_sel_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // The mux decodes {s0,s1} as a binary channel index.
    function automatic logic [SEL_W-1:0] idx_to_sel(input logic [SEL_W-1:0] idx);
        return idx;
    endfunction

    function automatic logic [NUM_CH-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_CH-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mux_sel_sequencer_rr_pick.sv
// Round-robin search: first requester at start, start+1, ... (mod NUM_CH).
// Purely combinational, zero latency. No backpressure.
module rr_pick
    import mux_sel_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  start,
    input  logic              mask_cur,
    output logic              found,
    output logic [SEL_W-1:0]  idx
);

    // Walk from the far end back so the nearest candidate wins; with mask_cur
    // the last slot (start-1, the current holder) is excluded.
    always_comb begin
        logic [SEL_W-1:0] w_cand;
        found  = 1'b0;
        idx    = start;
        w_cand = start;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            w_cand = start + SEL_W'(k);
            if (req[w_cand] && !(mask_cur && (k == NUM_CH - 1))) begin
                found = 1'b1;
                idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/mux_sel_sequencer.sv
// Time-sliced round-robin select generator for a 4:1 mux; optional lock via MUX_SEL_SEQUENCER_LOCK_EN.
// Latency: 1 cycle from request to registered grant/select/valid.
// Backpressure: none; a grant is held for up to DWELL cycles or until its request drops.
module mux_sel_sequencer
    import mux_sel_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
`ifdef MUX_SEL_SEQUENCER_LOCK_EN
    input  logic              lock,
`endif
    output logic              s0,
    output logic              s1,
    output logic [NUM_CH-1:0] gnt,
    output logic              valid
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL - 1);

    state_t             r_state;
    logic [SEL_W-1:0]   r_last;
    logic [SEL_W-1:0]   r_sel;
    logic [CNT_W-1:0]   r_cnt;
    logic [NUM_CH-1:0]  r_gnt;
    logic               r_valid;

    logic               w_found;
    logic [SEL_W-1:0]   w_idx;
    logic               w_cur_req;
    logic               w_lock_hold;
    logic               w_rearb;

`ifdef MUX_SEL_SEQUENCER_LOCK_EN
    assign w_lock_hold = lock;
`else
    assign w_lock_hold = 1'b0;
`endif

    // r_last doubles as the current holder while in GRANT.
    assign w_cur_req = req[r_last];
    assign w_rearb   = !w_cur_req || ((r_cnt == CNT_MAX) && !w_lock_hold);

    rr_pick u_pick (
        .req      (req),
        .start    (r_last + SEL_W'(1)),
        .mask_cur (r_state == GRANT),
        .found    (w_found),
        .idx      (w_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_last  <= SEL_W'(NUM_CH - 1);
            r_sel   <= '0;
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state <= GRANT;
                        r_last  <= w_idx;
                        r_sel   <= idx_to_sel(w_idx);
                        r_gnt   <= idx_to_onehot(w_idx);
                        r_valid <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                GRANT: begin
                    if (w_rearb) begin
                        if (w_found) begin
                            r_last  <= w_idx;
                            r_sel   <= idx_to_sel(w_idx);
                            r_gnt   <= idx_to_onehot(w_idx);
                            r_cnt   <= '0;
                        end else if (w_cur_req) begin
                            r_cnt   <= '0;
                        end else begin
                            // Select keeps its last value; valid marks y as stale.
                            r_state <= IDLE;
                            r_gnt   <= '0;
                            r_valid <= 1'b0;
                            r_cnt   <= '0;
                        end
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign s0    = r_sel[1];
    assign s1    = r_sel[0];
    assign gnt   = r_gnt;
    assign valid = r_valid;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Directed bench for mux_sel_sequencer with DWELL=4; lock steps only when MUX_SEL_SEQUENCER_LOCK_EN is defined.
module tb_mux_sel_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
`ifdef MUX_SEL_SEQUENCER_LOCK_EN
    logic       lock;
`endif
    logic       s0;
    logic       s1;
    logic [3:0] gnt;
    logic       valid;

    int n_assert = 0;
    int n_fail   = 0;

    mux_sel_sequencer #(.DWELL(4), .CNT_W(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
`ifdef MUX_SEL_SEQUENCER_LOCK_EN
        .lock  (lock),
`endif
        .s0    (s0),
        .s1    (s1),
        .gnt   (gnt),
        .valid (valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] e_gnt,
                       input logic [1:0] e_sel, input logic e_vld);
        n_assert++;
        assert ({gnt, s0, s1, valid} === {e_gnt, e_sel, e_vld}) else begin
            n_fail++;
            $error("FAIL %s: observed gnt=%b sel=%b%b valid=%b, expected gnt=%b sel=%b valid=%b",
                   tag, gnt, s0, s1, valid, e_gnt, e_sel, e_vld);
        end
    endtask

    initial begin
        logic [1:0] e;
        rst = 1'b1;
        req = 4'b0000;
`ifdef MUX_SEL_SEQUENCER_LOCK_EN
        lock = 1'b0;
`endif
        tick();
        tick();
        chk("reset", 4'b0000, 2'b00, 1'b0);
        rst = 1'b0;
        tick();
        chk("idle_no_req", 4'b0000, 2'b00, 1'b0);

        // Single requester: 1-cycle latency, then held across dwell expiries.
        req = 4'b0001;
        tick();
        chk("first_grant_a", 4'b0001, 2'b00, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_a", 4'b0001, 2'b00, 1'b1);
        end
        tick();                        // cnt now at DWELL-1
        chk("hold_a_cnt3", 4'b0001, 2'b00, 1'b1);
        req = 4'b0000;
        tick();
        chk("drop_at_expiry", 4'b0000, 2'b00, 1'b0);

        // All requesting: a,b,c,d for 4 cycles each, no bubble.
        rst = 1'b1;
        req = 4'b1111;
        tick();
        chk("reset_with_req", 4'b0000, 2'b00, 1'b0);
        rst = 1'b0;
        for (int k = 0; k < 32; k++) begin
            tick();
            e = 2'((k / 4) % 4);
            chk("rotate", 4'b0001 << e, e, 1'b1);
        end

        // Grant c, drop to idle (select holds), then wrap search to a.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b0100;
        tick();
        chk("grant_c", 4'b0100, 2'b10, 1'b1);
        tick();
        chk("hold_c", 4'b0100, 2'b10, 1'b1);
        req = 4'b0000;
        tick();
        chk("c_drop_idle", 4'b0000, 2'b10, 1'b0);
        req = 4'b0011;
        tick();
        chk("wrap_to_a", 4'b0001, 2'b00, 1'b1);

        // a drops -> b; b drops at cnt=1 -> d with no bubble.
        req = 4'b1010;
        tick();
        chk("switch_b", 4'b0010, 2'b01, 1'b1);
        tick();
        chk("hold_b_cnt1", 4'b0010, 2'b01, 1'b1);
        req = 4'b1000;
        tick();
        chk("b_drop_to_d", 4'b1000, 2'b11, 1'b1);

        // Reset mid-grant of d; with all requesting, a wins next.
        req = 4'b1111;
        tick();
        chk("hold_d", 4'b1000, 2'b11, 1'b1);
        rst = 1'b1;
        tick();
        chk("reset_mid_grant", 4'b0000, 2'b00, 1'b0);
        rst = 1'b0;
        tick();
        chk("after_reset_a", 4'b0001, 2'b00, 1'b1);

`ifdef MUX_SEL_SEQUENCER_LOCK_EN
        rst  = 1'b1;
        req  = 4'b0011;
        lock = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("lock_grant_a", 4'b0001, 2'b00, 1'b1);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("lock_hold_a", 4'b0001, 2'b00, 1'b1);
        end
        lock = 1'b0;
        tick();
        chk("unlock_b", 4'b0010, 2'b01, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_sel_sequencer.md
Name: mux_sel_sequencer

Overview:
- Round-robin, time-sliced select generator that drives the s0/s1 select pins of the 4:1 channel mux (inputs a,b,c,d) directly downstream.
- Arbitrates four per-channel request lines and holds each grant for a programmable dwell time.
- Emits a registered select, a one-hot grant and a valid flag so the mux output y is qualified.

Parameters:
- DWELL, 4: maximum consecutive cycles one channel holds the grant; legal range 1..255.
- CNT_W, 8: dwell counter width; must satisfy 2**CNT_W > DWELL.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  per-channel request; bit0=a, bit1=b, bit2=c, bit3=d.
- s0  output  1  mux select MSB (= chan_idx[1]).
- s1  output  1  mux select LSB (= chan_idx[0]).
- gnt  output  4  one-hot grant, same bit order as req.
- valid  output  1  high when a grant is active and y is meaningful.

Behaviour:
- Select encoding matches the mux: {s0,s1}=00 selects a, 01 selects b, 10 selects c, 11 selects d.
- All outputs are registered. s0, s1, gnt and valid change only on a clock edge and change together.
- Reset (rst=1 at an edge, any state, including mid-grant):
  - state=IDLE, gnt=0, valid=0, s0=0, s1=0, cnt=0.
  - Round-robin pointer last=3, so the first winner searched is channel 0.
- States:
  - IDLE: if req!=0, pick the first requesting channel in order last+1, last+2, ... (mod 4). Next edge: gnt=onehot(pick), {s0,s1}=pick, valid=1, cnt=0, last=pick, state=GRANT. If req==0, stay in IDLE with outputs at their reset values.
  - GRANT: cnt increments every cycle. Re-arbitration is triggered by either of:
    - (a) req[cur] deasserted (sampled this cycle);
    - (b) cnt==DWELL-1.
- On re-arbitration, search from cur+1 over the other channels:
  - Another channel requesting: switch to it on the next edge, valid stays 1 (no idle bubble), cnt=0, last=new.
  - No other channel, but req[cur] still high (case b only): keep cur, cnt=0.
  - No requests at all: go to IDLE; gnt=0, valid=0 and {s0,s1} hold their last value.
- Latency: req rising from all-zero gives valid=1 at the first edge after req is sampled (1 cycle).
- Simultaneous requests: round-robin order from last+1 resolves them; there is no fixed priority.
- Deassertion: if req[cur] drops in the same cycle cnt==DWELL-1, treat it as case (a).
- DWELL=1: the grant rotates every cycle among the requesters.
- Counter: cnt never exceeds DWELL-1 and does not wrap.

Optional Feature:
- Macro: MUX_SEL_SEQUENCER_LOCK_EN.
- When defined:
  - Adds input port lock (1 bit, listed after req).
  - While lock=1 in GRANT with req[cur]=1, the dwell expiry (b) is suppressed; cnt saturates at DWELL-1 and the grant holds indefinitely.
  - Deassertion (a) still re-arbitrates.
- When undefined: no lock port; behaviour exactly as above.

Decomposition:
- Package mux_sel_pkg:
  - NUM_CH=4, SEL_W=2;
  - state enum {IDLE, GRANT};
  - function idx_to_sel(idx) returning {s0,s1}.
- One sub-module, rr_pick (combinational):
  - inputs req[3:0], start[1:0], mask_cur;
  - outputs found, idx[1:0];
  - used for both the IDLE and GRANT searches.

Test Plan:
- Reset, then req=4'b0001 held → 1 cycle later gnt=0001, {s0,s1}=00, valid=1. gnt stays 0001 indefinitely; cnt restarts every 4 cycles.
- req=4'b1111 held, DWELL=4 → grants a,b,c,d for 4 cycles each, {s0,s1}=00,01,10,11, repeating; valid never drops.
- Grant on c (idx 2), req=4'b0100, then deassert bit2 with req=4'b0000 → next edge valid=0, gnt=0. Later req=4'b0011 → grant a (search from 3 wraps to 0).
- req=4'b1010 during a b-grant at cnt=1, then bit1 drops → next edge grant d ({s0,s1}=11), cnt=0, no bubble.
- rst=1 for one cycle mid-grant of d → next edge all outputs 0. With req=4'b1111 still held, the next grant is a.
- With LOCK_EN defined: lock=1, req=4'b0011 on a → a held for 20 cycles. Lock drops → b granted within DWELL cycles.
